map_picker: RTL and testbench

//  Parametrised, sequential successor to the combinational map selector. Picks one puzzle from NUM_MAPS

---
 rtl/sudoku_pkg.sv | 24 ++
 rtl/map_picker_lfsr16.sv | 19 +
 rtl/map_picker.sv | 150 +++++++++++++++
 tb/tb_map_picker.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared constants, LFSR step function and picker FSM state encoding for the
// sudoku map path.
package sudoku_pkg;

    localparam int unsigned DEF_CELLS    = 81;
    localparam int unsigned DEF_VAL_W    = 4;
    localparam int unsigned DEF_VIS_W    = 2;
    localparam int unsigned LFSR_W       = 16;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_LOAD,
        ST_DONE
    } state_t;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/map_picker_lfsr16.sv
// Free-running 16-bit Galois LFSR; loads seed while reset is held low.
module lfsr16
    import sudoku_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= seed;
        end else begin
            out <= lfsr_next(out);
        end
    end

endmodule

// File: rtl/map_picker.sv
// Sequential puzzle picker: draws an index by LFSR rejection sampling (or takes a
// fixed index), registers the chosen map/visibility and holds it until acked.
module map_picker
    import sudoku_pkg::*;
#(
    parameter int unsigned NUM_MAPS  = 15,
    parameter int unsigned CELLS     = DEF_CELLS,
    parameter int unsigned VAL_W     = DEF_VAL_W,
    parameter int unsigned VIS_W     = DEF_VIS_W,
    parameter int unsigned NO_REPEAT = 1,
    parameter int unsigned MAX_TRIES = 8,
    parameter logic [15:0] SEED      = DEFAULT_SEED,
    localparam int unsigned IDX_W    = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_MAPS*CELLS*VAL_W-1:0] maps_flat,
    input  logic [NUM_MAPS*CELLS*VIS_W-1:0] vis_flat,
    input  logic                            req,
    input  logic                            fixed_en,
    input  logic [IDX_W-1:0]                fixed_index,
    input  logic                            ack,
    output logic                            busy,
    output logic                            valid,
    output logic [IDX_W-1:0]                map_index,
    output logic [CELLS*VAL_W-1:0]          selected_map,
    output logic [CELLS*VIS_W-1:0]          selected_visibility
);

    localparam int unsigned MAP_W    = CELLS * VAL_W;
    localparam int unsigned VMAP_W   = CELLS * VIS_W;
    localparam int unsigned TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
    localparam logic [IDX_W:0] NUM_W    = (IDX_W+1)'(NUM_MAPS);
    localparam logic [IDX_W:0] LAST_W   = (IDX_W+1)'(NUM_MAPS - 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    state_t            state_q, state_d;
    logic [15:0]       rnd;
    logic [IDX_W-1:0]  idx_q, idx_d, last_q, cand, fallback, clamped;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [IDX_W:0]    wrap;
    logic              has_last_q, accept, load, take;
    logic              unused_rnd;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED_EFF),
        .out   (rnd)
    );

    // Only the low IDX_W bits form a candidate.
    assign unused_rnd = ^rnd[15:IDX_W];

    // Candidate qualification, fallback wrap (compare-and-clear) and fixed clamp
    always_comb begin
        cand     = rnd[IDX_W-1:0];
        wrap     = {1'b0, last_q} + (IDX_W+1)'(1);
        if (wrap == NUM_W) begin
            wrap = '0;
        end
        fallback = has_last_q ? wrap[IDX_W-1:0] : '0;
        clamped  = ({1'b0, fixed_index} > LAST_W) ? LAST_W[IDX_W-1:0] : fixed_index;
        accept   = ({1'b0, cand} < NUM_W) &&
                   !((NO_REPEAT != 0) && (NUM_MAPS > 1) && has_last_q && (cand == last_q));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tries_d = tries_q;
        load    = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (fixed_en) begin
                        state_d = ST_LOAD;
                        idx_d   = clamped;
                    end else begin
                        state_d = ST_DRAW;
                        tries_d = '0;
                    end
                end
            end
            ST_DRAW: begin
                if (accept) begin
                    state_d = ST_LOAD;
                    idx_d   = cand;
                end else if (tries_q == TRY_LAST) begin
                    state_d = ST_LOAD;
                    idx_d   = fallback;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (ack) begin
                    take    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tries_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tries_q <= tries_d;
        end
    end

    // Result registers; they keep the last pick after ack, only valid drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy                <= 1'b0;
            valid               <= 1'b0;
            map_index           <= '0;
            selected_map        <= '0;
            selected_visibility <= '0;
            last_q              <= '0;
            has_last_q          <= 1'b0;
        end else begin
            busy <= (state_d != ST_IDLE);
            if (load) begin
                valid               <= 1'b1;
                map_index           <= idx_q;
                selected_map        <= maps_flat[32'(idx_q) * MAP_W +: MAP_W];
                selected_visibility <= vis_flat[32'(idx_q) * VMAP_W +: VMAP_W];
            end
            if (take) begin
                valid      <= 1'b0;
                last_q     <= map_index;
                has_last_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_map_picker.sv
// Scoreboard bench for map_picker: three instances (default, single map with
// zero seed, single-try fallback), expected picks queued at request time.
module tb_map_picker;

    localparam int unsigned NM    = 15;
    localparam int unsigned CELLS = 81;
    localparam int unsigned MAP_W = CELLS * 4;
    localparam int unsigned VMAP  = CELLS * 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [MAP_W-1:0]    maps_mem [NM];
    logic [VMAP-1:0]     vis_mem  [NM];
    logic [NM*MAP_W-1:0] maps_flat;
    logic [NM*VMAP-1:0]  vis_flat;

    logic req_main = 1'b0, fen_main = 1'b0, ack_main = 1'b0;
    logic req_one  = 1'b0, fen_one  = 1'b0, ack_one  = 1'b0;
    logic req_fb   = 1'b0, fen_fb   = 1'b0, ack_fb   = 1'b0;
    logic [3:0] fidx_main = '0, fidx_fb = '0;
    logic [0:0] fidx_one = '0;
    logic busy_main, valid_main, busy_one, valid_one, busy_fb, valid_fb;
    logic [3:0] idx_main, idx_fb;
    logic [0:0] idx_one;
    logic [MAP_W-1:0] smap_main, smap_one, smap_fb;
    logic [VMAP-1:0]  svis_main, svis_one, svis_fb;

    map_picker u_main (
        .clk(clk), .reset(reset), .maps_flat(maps_flat), .vis_flat(vis_flat),
        .req(req_main), .fixed_en(fen_main), .fixed_index(fidx_main), .ack(ack_main),
        .busy(busy_main), .valid(valid_main), .map_index(idx_main),
        .selected_map(smap_main), .selected_visibility(svis_main)
    );

    map_picker #(.NUM_MAPS(1), .SEED(16'h0000)) u_one (
        .clk(clk), .reset(reset), .maps_flat(maps_mem[0]), .vis_flat(vis_mem[0]),
        .req(req_one), .fixed_en(fen_one), .fixed_index(fidx_one), .ack(ack_one),
        .busy(busy_one), .valid(valid_one), .map_index(idx_one),
        .selected_map(smap_one), .selected_visibility(svis_one)
    );

    map_picker #(.MAX_TRIES(1), .SEED(16'h1234)) u_fb (
        .clk(clk), .reset(reset), .maps_flat(maps_flat), .vis_flat(vis_flat),
        .req(req_fb), .fixed_en(fen_fb), .fixed_index(fidx_fb), .ack(ack_fb),
        .busy(busy_fb), .valid(valid_fb), .map_index(idx_fb),
        .selected_map(smap_fb), .selected_visibility(svis_fb)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int q_main[$];
    int q_one[$];
    int q_fb[$];
    bit has_last [3];
    int last_idx [3];
    int hits [NM];
    bit rnd_phase = 1'b0;
    bit prev_ok   = 1'b0;
    int prev_idx  = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] poly;
        poly = 16'hB400;
        return v[0] ? ((v >> 1) ^ poly) : (v >> 1);
    endfunction

    // Reference LFSRs, one per instance (u_one's zero seed becomes ACE1)
    logic [15:0] m_lfsr [3];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_lfsr[0] <= 16'hACE1;
            m_lfsr[1] <= 16'hACE1;
            m_lfsr[2] <= 16'h1234;
        end else begin
            for (int i = 0; i < 3; i++) m_lfsr[i] <= lfsr_step(m_lfsr[i]);
        end
    end

    function automatic void predict(input logic [15:0] start, input int nm, input int iw,
                                    input int mt, input bit hl, input int lst,
                                    output int idx, output int lat);
        logic [15:0] v;
        int c;
        v   = start;
        idx = hl ? (lst + 1) % nm : 0;
        lat = mt + 1;
        for (int t = 0; t < mt; t++) begin
            c = int'(v) & ((1 << iw) - 1);
            if (c < nm && !(hl && nm > 1 && c == lst)) begin
                idx = c;
                lat = t + 2;
                return;
            end
            v = lfsr_step(v);
        end
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [MAP_W-1:0] got,
                             input logic [MAP_W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic bit get_valid(input int sel);
        case (sel)
            0:       return valid_main;
            1:       return valid_one;
            default: return valid_fb;
        endcase
    endfunction

    function automatic bit get_busy(input int sel);
        case (sel)
            0:       return busy_main;
            1:       return busy_one;
            default: return busy_fb;
        endcase
    endfunction

    task automatic set_req(input int sel, input bit r, input bit f, input int fi);
        case (sel)
            0:       begin req_main = r; fen_main = f; fidx_main = 4'(fi); end
            1:       begin req_one  = r; fen_one  = f; end
            default: begin req_fb   = r; fen_fb   = f; fidx_fb   = 4'(fi); end
        endcase
    endtask

    task automatic set_ack(input int sel, input bit a);
        case (sel)
            0:       ack_main = a;
            1:       ack_one  = a;
            default: ack_fb   = a;
        endcase
    endtask

    // Monitor side: compare each fresh delivery with the head of its queue
    task automatic deliver(input int sel, input int got, input logic [MAP_W-1:0] m,
                           input logic [VMAP-1:0] v);
        int e, n;
        n = (sel == 0) ? q_main.size() : (sel == 1) ? q_one.size() : q_fb.size();
        n_checks++;
        if (n == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid: inst %0d got index %0d expected no delivery", sel, got);
            return;
        end
        case (sel)
            0:       e = q_main.pop_front();
            1:       e = q_one.pop_front();
            default: e = q_fb.pop_front();
        endcase
        check_int("map_index", got, e);
        if (e >= 0 && e < int'(NM)) begin
            check_vec("selected_map", m, maps_mem[e]);
            check_vec("selected_vis", MAP_W'(v), MAP_W'(vis_mem[e]));
        end
        if (sel == 0 && rnd_phase) begin
            check_int("index_in_range", (got < int'(NM)) ? 1 : 0, 1);
            if (prev_ok) check_int("no_repeat", (got != prev_idx) ? 1 : 0, 1);
            prev_ok  = 1'b1;
            prev_idx = got;
            if (got >= 0 && got < int'(NM)) hits[got] = 1;
        end
    endtask

    logic [2:0] v_prev = '0;
    always @(negedge clk) begin
        if (valid_main && !v_prev[0]) deliver(0, int'(idx_main), smap_main, svis_main);
        if (valid_one  && !v_prev[1]) deliver(1, int'(idx_one),  smap_one,  svis_one);
        if (valid_fb   && !v_prev[2]) deliver(2, int'(idx_fb),   smap_fb,   svis_fb);
        v_prev <= {valid_fb, valid_one, valid_main};
    end

    // Issue one request at the current negedge, queue the expectation, ack it.
    // want_idx/want_lat >= 0 are hand values; otherwise the reference predicts them.
    task automatic pick(input int sel, input bit fixed, input int fidx, input int want_idx,
                        input int want_lat, input bit ack_with_req);
        int nm, iw, mt, ei, el, cyc;
        logic [15:0] start;
        nm    = (sel == 1) ? 1 : int'(NM);
        iw    = (sel == 1) ? 1 : 4;
        mt    = (sel == 2) ? 1 : 8;
        start = lfsr_step(m_lfsr[sel]);
        if (fixed) begin
            ei = (fidx > nm - 1) ? nm - 1 : fidx;
            el = 1;
        end else begin
            predict(start, nm, iw, mt, has_last[sel], last_idx[sel], ei, el);
        end
        if (want_idx >= 0) ei = want_idx;
        if (want_lat >= 0) el = want_lat;
        case (sel)
            0:       q_main.push_back(ei);
            1:       q_one.push_back(ei);
            default: q_fb.push_back(ei);
        endcase
        set_req(sel, 1'b1, fixed, fidx);
        @(negedge clk);
        set_req(sel, 1'b0, 1'b0, 0);
        cyc = 0;
        while (!get_valid(sel) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_int("latency", cyc, el);
        set_ack(sel, 1'b1);
        if (ack_with_req) set_req(sel, 1'b1, 1'b0, 0);
        @(negedge clk);
        set_ack(sel, 1'b0);
        set_req(sel, 1'b0, 1'b0, 0);
        check_int("valid_after_ack", int'(get_valid(sel)), 0);
        check_int("busy_after_ack", int'(get_busy(sel)), 0);
        if (ack_with_req) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check_int("idle_after_ack_req", int'(get_busy(sel)), 0);
            end
        end
        has_last[sel] = 1'b1;
        last_idx[sel] = ei;
    endtask

    // Park at a negedge where the next draw's low nibble equals target
    task automatic wait_cand(input int sel, input int target);
        int n;
        logic [15:0] nx;
        n  = 0;
        nx = lfsr_step(m_lfsr[sel]);
        while (int'(nx[3:0]) != target && n < 300) begin
            @(negedge clk);
            n++;
            nx = lfsr_step(m_lfsr[sel]);
        end
        n_checks++;
        if (n >= 300) begin
            n_fail++;
            $display("FAIL wait_cand: candidate %0d not reached, last nibble %0d", target, nx[3:0]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < int'(NM); i++) begin
            for (int c = 0; c < int'(CELLS); c++) begin
                maps_mem[i][c*4 +: 4] = 4'((i * 5 + c * 3 + 1) % 16);
                vis_mem[i][c*2 +: 2]  = 2'((i * 3 + c) % 4);
            end
            maps_flat[i*MAP_W +: MAP_W] = maps_mem[i];
            vis_flat[i*VMAP +: VMAP]    = vis_mem[i];
            hits[i] = 0;
        end
        for (int s = 0; s < 3; s++) begin
            has_last[s] = 1'b0;
            last_idx[s] = 0;
        end

        repeat (3) @(negedge clk);
        check_int("rst_busy", int'(busy_main), 0);
        check_int("rst_valid", int'(valid_main), 0);
        check_int("rst_index", int'(idx_main), 0);
        check_vec("rst_map", smap_main, '0);
        check_int("rst_lfsr_main", int'(u_main.rnd), 16'hACE1);
        check_int("rst_lfsr_zero_seed", int'(u_one.rnd), 16'hACE1);
        check_int("rst_lfsr_fb", int'(u_fb.rnd), 16'h1234);
        reset = 1'b1;
        @(negedge clk);

        pick(0, 1'b1, 3, 3, 1, 1'b0);
        pick(0, 1'b1, 15, 14, 1, 1'b0);

        // Abort a pick while drawing
        set_req(0, 1'b1, 1'b0, 0);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 0);
        check_int("draw_busy", int'(busy_main), 1);
        reset = 1'b0;
        @(negedge clk);
        check_int("abort_busy", int'(busy_main), 0);
        check_int("abort_valid", int'(valid_main), 0);
        check_int("abort_index", int'(idx_main), 0);
        check_vec("abort_map", smap_main, '0);
        check_vec("abort_vis", MAP_W'(svis_main), '0);
        check_int("abort_lfsr", int'(u_main.rnd), 16'hACE1);
        reset = 1'b1;
        for (int s = 0; s < 3; s++) has_last[s] = 1'b0;
        @(negedge clk);

        rnd_phase = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pick(0, 1'b0, 0, -1, -1, i == 1000);
        end
        rnd_phase = 1'b0;
        for (int i = 0; i < int'(NM); i++) check_int("coverage", hits[i], 1);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pick(1, 1'b0, 0, 0, -1, 1'b0);
        end

        wait_cand(2, 15);
        pick(2, 1'b0, 0, 0, 2, 1'b0);
        pick(2, 1'b1, 14, 14, 1, 1'b0);
        wait_cand(2, 14);
        pick(2, 1'b0, 0, 0, 2, 1'b0);
        pick(2, 1'b1, 5, 5, 1, 1'b0);
        wait_cand(2, 5);
        pick(2, 1'b0, 0, 6, 2, 1'b0);
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pick(2, 1'b0, 0, -1, -1, 1'b0);
        end

        repeat (2) @(negedge clk);
        check_int("queue_drain", q_main.size() + q_one.size() + q_fb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
